seq_add_n: RTL and testbench
============================

Name: seq_add_n

Overview:
- Parametrised multi-cycle adder/subtractor, successor to the team's single-cycle 4-bit adder.
- Processes a WIDTH-bit operation CHUNK bits per clock through one CHUNK-bit adder slice and a registered carry.
- Uses a start/busy/done handshake.
- Used where wide arithmetic must stay off the critical path and area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NCH (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- in_0  input  WIDTH  operand A; latched on accepted start.
- in_1  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in (add) / borrow-in (sub); latched on accepted start.
- sub  input  1  0: A+B+cin; 1: A-B-cin; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- out  output  WIDTH  result; holds last completed value.
- cout  output  1  final carry; for sub, 1 = no borrow.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; out=0, cout=0, done=0, busy=0 (and ovf=0 when enabled).
  - Any in-flight operation is abandoned; no done pulse for it.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> accept and go to RUN.
- Accept latches:
  - A=in_0.
  - B=in_1 XOR {WIDTH{sub}}.
  - carry=cin XOR sub, so sub computes A + ~B + ~cin = A-B-cin.
  - chunk index k=0.
- RUN: each edge computes {c,s} = A[k*CHUNK+:CHUNK] + B[k*CHUNK+:CHUNK] + carry.
  - Writes s into the internal result slice k; carry=c; k++.
  - On the edge processing k=NCH-1: out=full result, cout=c, done=1, go to DONE.
- Latency: done is high exactly NCH cycles after the edge that accepted start.
  - NCH=1 (CHUNK=WIDTH) gives 1-cycle latency.
- DONE (one cycle): done=1, busy=0.
  - start=1 -> accept new operation, go to RUN (back-to-back, no idle gap).
  - Otherwise go to IDLE.
  - done deasserts on the next edge in both cases.
- start in RUN is ignored: not queued, and latched operands are unaffected.
- out and cout change only at completion; they hold between operations and are never partial.
- Input changes after acceptance have no effect.
- Wrap-around: results are modulo 2^WIDTH; the carry/borrow is reported only via cout.
- busy and done are never high together.

Optional Feature:
- Macro SEQ_ADD_N_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow of the operation.
  - ovf = (A[MSB]==B'[MSB]) && (result[MSB]!=A[MSB]), where B' is the post-inversion operand.
  - Updated with out at completion, held otherwise, reset to 0.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan (WIDTH=16, CHUNK=4, NCH=4):
- Reset: hold rst_n=0 for 2 edges, then release -> out=0x0000, cout=0, done=0, busy=0; ovf=0 when enabled.
- Add: in_0=0x1234, in_1=0x4321, cin=0, sub=0, start pulse -> busy high for 4 cycles; done high 4 cycles after accept; out=0x5555, cout=0.
- Full carry ripple across all chunks: 0xFFFF+0x0000, cin=1 -> out=0x0000, cout=1. Then 0x00FF+0x0001, cin=0 -> out=0x0100, cout=0.
- Subtract:
  - 0x0005-0x0007, cin=0 -> out=0xFFFE, cout=0.
  - 0x0007-0x0005, cin=1 -> out=0x0001, cout=1.
- Handshake:
  - start re-pulsed with different operands during RUN -> ignored, first result unchanged.
  - start held high in the DONE cycle with 0x0001+0x0001 -> second done 4 cycles later, out=0x0002.
- Reset mid-operation and overflow:
  - rst_n=0 on the 2nd RUN cycle -> no done, out=0.
  - With SEQ_ADD_N_OVF_EN: 0x7FFF+0x0001 -> out=0x8000, ovf=1.
  - With SEQ_ADD_N_OVF_EN: 0x8000-0x0001 -> out=0x7FFF, ovf=1.

Source files
------------

// File: rtl/seq_add_n.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock through one slice with a registered carry.
// Optional signed-overflow output enabled by defining SEQ_ADD_N_OVF_EN.
module seq_add_n #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout
`ifdef SEQ_ADD_N_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_n;
    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [KW-1:0]      k_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   res_next_s;
    logic [CHUNK:0]     sum_s;
    int                 idx_s;
    logic [WIDTH-1:0]   out_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
`ifdef SEQ_ADD_N_OVF_EN
    logic               ovf_r;
    logic               ovf_s;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode and start acceptance (start is only honoured in IDLE or DONE)
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        last_s   = (k_r == K_LAST);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_n  = ST_RUN;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_n  = ST_RUN;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // One CHUNK-wide slice addition; the result merged with earlier slices feeds the final write
    always_comb begin
        idx_s      = int'(k_r) * CHUNK;
        sum_s      = {1'b0, a_r[idx_s +: CHUNK]} + {1'b0, b_r[idx_s +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_r};
        res_next_s = res_r;
        res_next_s[idx_s +: CHUNK] = sum_s[CHUNK-1:0];
    end

`ifdef SEQ_ADD_N_OVF_EN
    // b_r already holds the inverted operand for subtraction, so one rule covers add and sub
    always_comb begin
        ovf_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_next_s[WIDTH-1] != a_r[WIDTH-1]);
    end
`endif

    // Operand latch, chunk sequencing and result/flag update at completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            k_r     <= {KW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
`ifdef SEQ_ADD_N_OVF_EN
            ovf_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r     <= in_0;
            b_r     <= in_1 ^ {WIDTH{sub}};
            carry_r <= cin ^ sub;
            k_r     <= {KW{1'b0}};
        end else if (state_r == ST_RUN) begin
            res_r   <= res_next_s;
            carry_r <= sum_s[CHUNK];
            k_r     <= k_r + KW'(1);
            if (last_s) begin
                out_r  <= res_next_s;
                cout_r <= sum_s[CHUNK];
`ifdef SEQ_ADD_N_OVF_EN
                ovf_r  <= ovf_s;
`endif
            end
        end
    end

    // Handshake outputs registered from the next state so they align with state_r
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_n == ST_RUN);
            done_r <= (state_n == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;
    assign cout = cout_r;
`ifdef SEQ_ADD_N_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_seq_add_n.sv
// Scoreboard bench for seq_add_n (WIDTH=16, CHUNK=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_add_n;

    localparam int NCH = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_0;
    logic [15:0] in_1;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [15:0] out;
    logic        cout;
    logic        ovf_w;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        v;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] cyc      = 32'd0;

    seq_add_n #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .in_0  (in_0),
        .in_1  (in_1),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .cout  (cout)
`ifdef SEQ_ADD_N_OVF_EN
        ,
        .ovf   (ovf_w)
`endif
    );

`ifndef SEQ_ADD_N_OVF_EN
    assign ovf_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result, at the expected cycle
    always @(negedge clk) begin
        if (busy || done) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_done: got done=1 expected none (out=0x%0h)", out);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out", {16'd0, out}, {16'd0, e.res});
                check("cout", {31'd0, cout}, {31'd0, e.c});
`ifdef SEQ_ADD_N_OVF_EN
                check("ovf", {31'd0, ovf_w}, {31'd0, e.v});
`endif
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive from just after a negedge; returns #1 after the accepting edge
    task automatic issue_now(input logic [15:0] a, input logic [15:0] b, input logic ci,
                             input logic s, input logic [15:0] r, input logic c, input logic v);
        exp_t e;
        in_0  = a;
        in_1  = b;
        cin   = ci;
        sub   = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res = r;
        e.c   = c;
        e.v   = v;
        e.cyc = cyc + NCH;
        q.push_back(e);
        start = 1'b0;
        in_0  = ~a;
        in_1  = ~b;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic s, input logic [15:0] r, input logic c, input logic v);
        @(negedge clk);
        issue_now(a, b, ci, s, r, c, v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        in_0  = 16'h0000;
        in_1  = 16'h0000;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out", {16'd0, out}, 32'h0);
        check("rst_cout", {31'd0, cout}, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_ovf", {31'd0, ovf_w}, 32'h0);

        // Plain add with busy window
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        for (int i = 0; i < NCH; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        check("busy_after_run", {31'd0, busy}, 32'd0);
        drain();

        // Carry ripple through all chunks, then partial ripple
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        drain();
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain();

        // Subtract with and without borrow-in
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        drain();
        issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
        drain();

        // start during RUN with different operands is ignored
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        in_0  = 16'hAAAA;
        in_1  = 16'h5555;
        sub   = 1'b1;
        cin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);
        check("ignored_start_out", {16'd0, out}, 32'h3333);

        // Back-to-back: start held in the DONE cycle
        issue(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        issue_now(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();

        // Reset on the second RUN cycle abandons the operation
        @(negedge clk);
        in_0  = 16'hFFFF;
        in_1  = 16'h0001;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_out", {16'd0, out}, 32'h0);
        check("midrst_cout", {31'd0, cout}, 32'h0);
        repeat (8) @(negedge clk);
        check("midrst_done", {31'd0, done}, 32'd0);

`ifdef SEQ_ADD_N_OVF_EN
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        drain();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();
`endif

        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
